// File: rtl/core_pkg.sv
// Shared core definitions used by the fetcher, the LSU and the per-core
// control unit: core FSM encoding, LSU lane states and the fetcher handshake.
package core_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

endpackage

// File: rtl/pc_min_select.sv
// Minimum-PC selector: reduces the lane PCs of the valid lanes to their
// minimum, flags every valid lane sitting at that minimum and reports whether
// any lane was valid at all. Purely combinational.
module pc_min_select #(
  parameter int T       = 4,
  parameter int PC_BITS = 8
) (
  input  logic [PC_BITS*T-1:0] lane_pc,
  input  logic [T-1:0]         valid,
  output logic [PC_BITS-1:0]   min_pc,
  output logic [T-1:0]         match,
  output logic                 any_valid
);

  // Leaf count rounded up to a power of two; padding leaves are invalid.
  localparam int NP = (T <= 1) ? 1 : (1 << $clog2(T));

  logic [PC_BITS-1:0] leaf_val [NP];
  logic               leaf_vld [NP];
  logic [PC_BITS-1:0] node_val [NP];
  logic               node_vld [NP];

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_leaf
      if (gi < T) begin : g_lane
        assign leaf_val[gi] = lane_pc[gi*PC_BITS +: PC_BITS];
        assign leaf_vld[gi] = valid[gi];
      end else begin : g_pad
        assign leaf_val[gi] = '0;
        assign leaf_vld[gi] = 1'b0;
      end
    end
  endgenerate

  // Pairwise tree, folded in place level by level; invalid children never win.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      node_val[i] = leaf_val[i];
      node_vld[i] = leaf_vld[i];
    end
    for (int w = NP / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        if (node_vld[2*i] && (!node_vld[2*i+1] || node_val[2*i] <= node_val[2*i+1]))
          node_val[i] = node_val[2*i];
        else
          node_val[i] = node_val[2*i+1];
        node_vld[i] = node_vld[2*i] | node_vld[2*i+1];
      end
    end
    min_pc    = node_val[0];
    any_valid = node_vld[0];
  end

  // Ties issue together: selection is by value, not by lane index.
  generate
    for (gi = 0; gi < T; gi++) begin : g_match
      assign match[gi] = valid[gi] && (lane_pc[gi*PC_BITS +: PC_BITS] == min_pc);
    end
  endgenerate

endmodule

// File: rtl/simt_core_ctrl.sv
// Per-core SIMT control unit: sequences the core FSM and produces the issuing
// PC and active-thread mask for one block.
// Build option SIMT_DIVERGENCE_EN: per-lane PCs with min-PC reconvergence and
// per-lane retirement. Without it the core runs in lockstep on lane 0's PC.
module simt_core_ctrl
  import core_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
  input  logic [2:0]                           fetcher_state,
  input  logic                                 decoded_mem_read_enable,
  input  logic                                 decoded_mem_write_enable,
  input  logic                                 decoded_ret,
  input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                           core_state,
  output logic [PC_BITS-1:0]                   current_pc,
  output logic [THREADS_PER_BLOCK-1:0]         active_mask,
  output logic                                 done
);

  localparam int T    = THREADS_PER_BLOCK;
  localparam int TC_W = $clog2(T) + 1;

  localparam logic [2:0] ST_IDLE    = 3'(CORE_IDLE);
  localparam logic [2:0] ST_FETCH   = 3'(CORE_FETCH);
  localparam logic [2:0] ST_DECODE  = 3'(CORE_DECODE);
  localparam logic [2:0] ST_REQUEST = 3'(CORE_REQUEST);
  localparam logic [2:0] ST_WAIT    = 3'(CORE_WAIT);
  localparam logic [2:0] ST_EXECUTE = 3'(CORE_EXECUTE);
  localparam logic [2:0] ST_UPDATE  = 3'(CORE_UPDATE);
  localparam logic [2:0] ST_DONE    = 3'(CORE_DONE);

  logic [2:0]         state_reg;
  logic [PC_BITS-1:0] pc_reg;
  logic [T-1:0]       mask_reg;
  logic               done_reg;

  logic [T-1:0] count_mask;
  logic [T-1:0] lane_mem_done;
  logic         mem_done;
  logic         is_mem;

  genvar gi;
  generate
    for (gi = 0; gi < T; gi++) begin : g_lane
      assign count_mask[gi]    = (TC_W'(gi) < thread_count);
      // Lanes outside the issuing group never hold up the memory wait.
      assign lane_mem_done[gi] = !mask_reg[gi] || (lsu_state[2*gi +: 2] == LSU_DONE);
    end
  endgenerate

  assign mem_done = &lane_mem_done;
  assign is_mem   = decoded_mem_read_enable | decoded_mem_write_enable;

`ifdef SIMT_DIVERGENCE_EN
  logic [PC_BITS-1:0]   lane_pc_reg [T];
  logic [T-1:0]         retired_reg;
  logic [T-1:0]         enabled_reg;
  logic [T-1:0]         retired_next;
  logic [PC_BITS*T-1:0] lane_pc_next;
  logic [PC_BITS-1:0]   sel_pc;
  logic [T-1:0]         sel_mask;
  logic                 sel_any;

  // Lane PCs as they will stand after UPDATE: RET freezes them, otherwise
  // only the issuing lanes take their computed next PC.
  generate
    for (gi = 0; gi < T; gi++) begin : g_next
      assign lane_pc_next[gi*PC_BITS +: PC_BITS] =
        (mask_reg[gi] && !decoded_ret) ? next_pc[gi*PC_BITS +: PC_BITS] : lane_pc_reg[gi];
    end
  endgenerate

  assign retired_next = decoded_ret ? (retired_reg | mask_reg) : retired_reg;

  pc_min_select #(.T(T), .PC_BITS(PC_BITS)) u_min (
    .lane_pc   (lane_pc_next),
    .valid     (enabled_reg & ~retired_next),
    .min_pc    (sel_pc),
    .match     (sel_mask),
    .any_valid (sel_any)
  );
`else
  logic unused_next_pc;
  assign unused_next_pc = ^next_pc;
`endif

  // Core FSM plus PC/mask/retirement bookkeeping; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      mask_reg  <= '0;
      done_reg  <= 1'b0;
`ifdef SIMT_DIVERGENCE_EN
      retired_reg <= '0;
      enabled_reg <= '0;
      for (int i = 0; i < T; i++) lane_pc_reg[i] <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            pc_reg <= '0;
`ifdef SIMT_DIVERGENCE_EN
            retired_reg <= '0;
            enabled_reg <= count_mask;
            for (int i = 0; i < T; i++) lane_pc_reg[i] <= '0;
`endif
            if (thread_count == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              mask_reg  <= '0;
            end else begin
              state_reg <= ST_FETCH;
              mask_reg  <= count_mask;
            end
          end
        end
        ST_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_reg <= ST_DECODE;
        ST_DECODE:  state_reg <= ST_REQUEST;
        ST_REQUEST: state_reg <= ST_WAIT;
        ST_WAIT:    if (!is_mem || mem_done) state_reg <= ST_EXECUTE;
        ST_EXECUTE: state_reg <= ST_UPDATE;
        ST_UPDATE: begin
`ifdef SIMT_DIVERGENCE_EN
          retired_reg <= retired_next;
          for (int i = 0; i < T; i++) lane_pc_reg[i] <= lane_pc_next[i*PC_BITS +: PC_BITS];
          if (!sel_any) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= ST_FETCH;
            mask_reg  <= sel_mask;
            pc_reg    <= sel_pc;
          end
`else
          if (decoded_ret) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= ST_FETCH;
            pc_reg    <= next_pc[PC_BITS-1:0];
          end
`endif
        end
        ST_DONE:    state_reg <= ST_DONE;
        default:    state_reg <= ST_IDLE;
      endcase
    end
  end

  assign core_state  = state_reg;
  assign current_pc  = pc_reg;
  assign active_mask = mask_reg;
  assign done        = done_reg;

endmodule
